// File: rtl/pkt_bufid_refcnt_manager.sv
// Per-buffer reference-count table: forwarding sets the fan-out count, each transmitted copy
// releases one reference, and a bufid whose count reaches zero is handed back to the free pool.
module pkt_bufid_refcnt_manager #(
    parameter int unsigned BUFID_W = 9,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DEPTH   = 512
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BUFID_W-1:0] iv_pkt_bufid,
    input  logic [CNT_W-1:0]   iv_pkt_bufid_cnt,
    input  logic               i_pkt_bufid_req,
    output logic               o_pkt_bufid_ack,
    input  logic [BUFID_W-1:0] iv_release_bufid,
    input  logic               i_release_req,
    output logic               o_release_ack,
    output logic [BUFID_W-1:0] ov_free_bufid,
    output logic               o_free_req,
    input  logic               i_free_ack,
    output logic               o_init_done,
    output logic               o_err_underflow,
    output logic               o_err_overwrite,
    output logic [BUFID_W:0]   ov_live_cnt
);

    localparam logic [BUFID_W:0]   LiveMax  = (BUFID_W + 1)'(DEPTH);
    localparam logic [BUFID_W-1:0] LastAddr = BUFID_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StSetRd,
        StSetWr,
        StRelRd,
        StRelWr,
        StFreeWait
    } state_e;

    state_e             state_q;
    logic [BUFID_W-1:0] clr_addr_q;
    logic [BUFID_W-1:0] bufid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   rd_q;
    logic               set_ack_q;
    logic               rel_ack_q;
    logic               err_uf_q;
    logic               err_ow_q;
    logic               free_req_q;
    logic [BUFID_W-1:0] free_bufid_q;
    logic               init_done_q;
    logic [BUFID_W:0]   live_q;
    // One-cycle hold-off per requester so a req dropped late after its ack is not re-served.
    logic               hold_set_q;
    logic               hold_rel_q;

    logic [CNT_W-1:0]   mem_q [DEPTH];
    logic               mem_we;
    logic [BUFID_W-1:0] mem_addr;
    logic [CNT_W-1:0]   mem_wdata;
    logic [CNT_W-1:0]   mem_rdata;

    // Single port: INIT walks the clear address, every other state uses the latched bufid.
    assign mem_addr  = (state_q == StInit) ? clr_addr_q : bufid_q;
    assign mem_rdata = mem_q[mem_addr];

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
            end
            StSetWr: begin
                mem_we    = 1'b1;
                mem_wdata = cnt_q;
            end
            StRelWr: begin
                mem_we    = (rd_q != '0);
                mem_wdata = rd_q - CNT_W'(1);
            end
            default: begin
                mem_we    = 1'b0;
                mem_wdata = '0;
            end
        endcase
        if (i_rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StInit;
            clr_addr_q   <= '0;
            bufid_q      <= '0;
            cnt_q        <= '0;
            rd_q         <= '0;
            set_ack_q    <= 1'b0;
            rel_ack_q    <= 1'b0;
            err_uf_q     <= 1'b0;
            err_ow_q     <= 1'b0;
            free_req_q   <= 1'b0;
            free_bufid_q <= '0;
            init_done_q  <= 1'b0;
            live_q       <= '0;
            hold_set_q   <= 1'b0;
            hold_rel_q   <= 1'b0;
        end else begin
            set_ack_q <= 1'b0;
            rel_ack_q <= 1'b0;
            err_uf_q  <= 1'b0;
            err_ow_q  <= 1'b0;
            case (state_q)
                StInit: begin
                    if (clr_addr_q == LastAddr) begin
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                StIdle: begin
                    hold_set_q <= 1'b0;
                    hold_rel_q <= 1'b0;
                    if (i_pkt_bufid_req && !hold_set_q) begin
                        bufid_q <= iv_pkt_bufid;
                        cnt_q   <= iv_pkt_bufid_cnt;
                        state_q <= StSetRd;
                    end else if (i_release_req && !hold_rel_q) begin
                        bufid_q <= iv_release_bufid;
                        state_q <= StRelRd;
                    end
                end
                // Ack and error flags are registered here so they are visible during the WR cycle.
                StSetRd: begin
                    rd_q      <= mem_rdata;
                    set_ack_q <= 1'b1;
                    err_ow_q  <= (mem_rdata != '0);
                    state_q   <= StSetWr;
                end
                StSetWr: begin
                    hold_set_q <= 1'b1;
                    if (rd_q != '0 && cnt_q == '0) begin
                        if (live_q != '0) begin
                            live_q <= live_q - 1'b1;
                        end
                    end else if (rd_q == '0 && cnt_q != '0) begin
                        if (live_q != LiveMax) begin
                            live_q <= live_q + 1'b1;
                        end
                    end
                    if (cnt_q == '0) begin
                        free_req_q   <= 1'b1;
                        free_bufid_q <= bufid_q;
                        state_q      <= StFreeWait;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRelRd: begin
                    rd_q      <= mem_rdata;
                    rel_ack_q <= 1'b1;
                    err_uf_q  <= (mem_rdata == '0);
                    state_q   <= StRelWr;
                end
                StRelWr: begin
                    hold_rel_q <= 1'b1;
                    if (rd_q == CNT_W'(1)) begin
                        if (live_q != '0) begin
                            live_q <= live_q - 1'b1;
                        end
                        free_req_q   <= 1'b1;
                        free_bufid_q <= bufid_q;
                        state_q      <= StFreeWait;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StFreeWait: begin
                    if (i_free_ack) begin
                        free_req_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    assign o_pkt_bufid_ack = set_ack_q;
    assign o_release_ack   = rel_ack_q;
    assign ov_free_bufid   = free_bufid_q;
    assign o_free_req      = free_req_q;
    assign o_init_done     = init_done_q;
    assign o_err_underflow = err_uf_q;
    assign o_err_overwrite = err_ow_q;
    assign ov_live_cnt     = live_q;

endmodule

// File: tb/tb_pkt_bufid_refcnt_manager.sv
// Directed bench for pkt_bufid_refcnt_manager: expected acks, error flags and freed bufids are
// queued when stimulus is driven and compared when the DUT responds.
module tb_pkt_bufid_refcnt_manager;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] pkt_bufid;
    logic [3:0] pkt_cnt;
    logic       pkt_req;
    logic       pkt_ack;
    logic [8:0] rel_bufid;
    logic       rel_req;
    logic       rel_ack;
    logic [8:0] free_bufid;
    logic       free_req;
    logic       free_ack;
    logic       init_done;
    logic       err_uf;
    logic       err_ow;
    logic [9:0] live_cnt;

    int checks = 0;
    int errors = 0;

    logic       exp_ow_q[$];
    logic       exp_uf_q[$];
    logic [8:0] exp_free_q[$];

    pkt_bufid_refcnt_manager dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .iv_pkt_bufid     (pkt_bufid),
        .iv_pkt_bufid_cnt (pkt_cnt),
        .i_pkt_bufid_req  (pkt_req),
        .o_pkt_bufid_ack  (pkt_ack),
        .iv_release_bufid (rel_bufid),
        .i_release_req    (rel_req),
        .o_release_ack    (rel_ack),
        .ov_free_bufid    (free_bufid),
        .o_free_req       (free_req),
        .i_free_ack       (free_ack),
        .o_init_done      (init_done),
        .o_err_underflow  (err_uf),
        .o_err_overwrite  (err_ow),
        .ov_live_cnt      (live_cnt)
    );

    always #4 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_set(input logic [8:0] b, input logic [3:0] c, input logic exp_ow,
                          output int lat);
        exp_ow_q.push_back(exp_ow);
        pkt_bufid = b;
        pkt_cnt   = c;
        pkt_req   = 1'b1;
        lat       = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (pkt_ack) begin
                lat = n;
                break;
            end
        end
        check("set_ack_seen", 32'(lat != 0), 1);
        check("set_overwrite", 32'(err_ow), 32'(exp_ow_q.pop_front()));
        pkt_req = 1'b0;
    endtask

    task automatic rel_start(input logic [8:0] b, input logic exp_uf);
        exp_uf_q.push_back(exp_uf);
        rel_bufid = b;
        rel_req   = 1'b1;
    endtask

    task automatic rel_wait();
        int got = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rel_ack) begin
                got = 1;
                break;
            end
        end
        check("rel_ack_seen", got, 1);
        check("rel_underflow", 32'(err_uf), 32'(exp_uf_q.pop_front()));
        rel_req = 1'b0;
    endtask

    task automatic do_rel(input logic [8:0] b, input logic exp_uf);
        rel_start(b, exp_uf);
        rel_wait();
    endtask

    task automatic free_handshake();
        for (int n = 0; n < 40 && !free_req; n++) @(negedge clk);
        check("free_req_high", 32'(free_req), 1);
        check("free_bufid", 32'(free_bufid), 32'(exp_free_q.pop_front()));
        free_ack = 1'b1;
        @(negedge clk);
        free_ack = 1'b0;
        check("free_req_drop", 32'(free_req), 0);
    endtask

    initial begin
        int lat;
        int saw_ack;
        int hold_bad;
        rst       = 1'b1;
        pkt_bufid = '0;
        pkt_cnt   = '0;
        pkt_req   = 1'b0;
        rel_bufid = '0;
        rel_req   = 1'b0;
        free_ack  = 1'b0;

        // Reset for one edge, then watch INIT with requests pending.
        @(negedge clk);
        check("rst_set_ack", 32'(pkt_ack), 0);
        check("rst_rel_ack", 32'(rel_ack), 0);
        check("rst_free_req", 32'(free_req), 0);
        check("rst_free_bufid", 32'(free_bufid), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_err_uf", 32'(err_uf), 0);
        check("rst_err_ow", 32'(err_ow), 0);
        check("rst_live", 32'(live_cnt), 0);
        rst       = 1'b0;
        pkt_bufid = 9'h07;
        pkt_cnt   = 4'd2;
        pkt_req   = 1'b1;
        rel_bufid = 9'h07;
        rel_req   = 1'b1;
        saw_ack   = 0;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk);
            if (pkt_ack || rel_ack) saw_ack = 1;
            if (i == 511) check("init_done_early", 32'(init_done), 0);
            if (i == 512) check("init_done_512", 32'(init_done), 1);
        end
        pkt_req = 1'b0;
        rel_req = 1'b0;
        check("no_ack_in_init", saw_ack, 0);
        repeat (3) @(negedge clk);

        // Set 0x05 to 3, release three times, fourth release underflows.
        do_set(9'h05, 4'd3, 1'b0, lat);
        @(negedge clk);
        check("live_after_set05", 32'(live_cnt), 1);
        do_rel(9'h05, 1'b0);
        do_rel(9'h05, 1'b0);
        @(negedge clk);
        check("no_free_before_3rd", 32'(free_req), 0);
        check("live_before_3rd", 32'(live_cnt), 1);
        exp_free_q.push_back(9'h05);
        do_rel(9'h05, 1'b0);
        free_handshake();
        check("live_after_free05", 32'(live_cnt), 0);
        do_rel(9'h05, 1'b1);
        repeat (3) @(negedge clk);

        // Set 0x1FF with count 0: immediate free, held off by a slow pool.
        exp_free_q.push_back(9'h1FF);
        do_set(9'h1FF, 4'd0, 1'b0, lat);
        check("set_latency", lat, 2);
        @(negedge clk);
        check("set_ack_one_cycle", 32'(pkt_ack), 0);
        check("free_req_1ff", 32'(free_req), 1);
        check("live_after_1ff", 32'(live_cnt), 0);
        rel_start(9'h10, 1'b1);
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!free_req || rel_ack) hold_bad++;
        end
        check("free_wait_hold", hold_bad, 0);
        free_handshake();
        rel_wait();
        @(negedge clk);
        check("live_after_uf", 32'(live_cnt), 0);
        do_rel(9'h10, 1'b1);

        // Simultaneous set and release on 0x20 (count 2): set wins, release sees 4.
        do_set(9'h20, 4'd2, 1'b0, lat);
        repeat (3) @(negedge clk);
        rel_start(9'h20, 1'b0);
        do_set(9'h20, 4'd4, 1'b1, lat);
        check("rel_not_before_set", 32'(rel_ack), 0);
        rel_wait();
        @(negedge clk);
        check("live_after_ow", 32'(live_cnt), 1);
        do_rel(9'h20, 1'b0);
        do_rel(9'h20, 1'b0);
        @(negedge clk);
        check("no_free_at_1", 32'(free_req), 0);
        exp_free_q.push_back(9'h20);
        do_rel(9'h20, 1'b0);
        free_handshake();
        check("live_after_free20", 32'(live_cnt), 0);

        // Reset while waiting for the pool: everything abandoned, table cleared again.
        do_set(9'h44, 4'd5, 1'b0, lat);
        exp_free_q.push_back(9'h33);
        do_set(9'h33, 4'd0, 1'b0, lat);
        @(negedge clk);
        check("free_req_before_rst", 32'(free_req), 1);
        check("live_before_rst", 32'(live_cnt), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_free_req", 32'(free_req), 0);
        check("rst_mid_live", 32'(live_cnt), 0);
        check("rst_mid_init_done", 32'(init_done), 0);
        rst = 1'b0;
        exp_free_q.delete();
        for (int n = 0; n < 600 && !init_done; n++) @(negedge clk);
        check("reinit_done", 32'(init_done), 1);
        for (int i = 0; i < 512; i++) begin
            do_rel(9'(i), 1'b1);
        end
        @(negedge clk);
        check("final_live", 32'(live_cnt), 0);
        check("final_free_req", 32'(free_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_bufid_refcnt_manager.md
Name: pkt_bufid_refcnt_manager

Overview:
- Responder for the forward-lookup action stage's per-buffer fan-out request: stores (bufid, fan-out count) as a per-buffer reference count.
- Accepts one release per transmitted copy from the output-port side and decrements that count.
- When a count reaches zero, returns the bufid to the free-buffer pool by handshake.
- Sits in the centralized packet-buffer manager, between forwarding and the free-bufid FIFO.

Parameters:
- BUFID_W, 9, buffer-id width
- CNT_W, 4, reference-count width
- DEPTH, 512, number of buffers (2**BUFID_W)

Ports:
- i_clk  input  1  125 MHz clock
- i_rst  input  1  reset, synchronous, active-high
- iv_pkt_bufid  input  BUFID_W  bufid whose count is set
- iv_pkt_bufid_cnt  input  CNT_W  number of copies forwarded
- i_pkt_bufid_req  input  1  set request, held with data until ack
- o_pkt_bufid_ack  output  1  one-cycle set acknowledge
- iv_release_bufid  input  BUFID_W  bufid of one finished copy
- i_release_req  input  1  release request, held until ack
- o_release_ack  output  1  one-cycle release acknowledge
- ov_free_bufid  output  BUFID_W  bufid returned to pool
- o_free_req  output  1  free request, held until ack
- i_free_ack  input  1  free acknowledge from pool
- o_init_done  output  1  table clear complete
- o_err_underflow  output  1  one-cycle pulse: release on a zero count
- o_err_overwrite  output  1  one-cycle pulse: set on a nonzero count
- ov_live_cnt  output  BUFID_W+1  buffers currently holding a nonzero count

Behaviour:
- Clock and reset: one clock domain (i_clk). Reset is synchronous and active-high (i_rst).
- Storage: count table, DEPTH x CNT_W, single-port. One access per cycle.
- Reset values: all outputs 0; FSM enters INIT; clear address = 0.
- Reset asserted mid-operation: state and every pending handshake are abandoned; the table is cleared again.
- INIT:
  - Writes 0 to address 0..DEPTH-1, one per cycle (DEPTH cycles).
  - At the last address: o_init_done <= 1 (held until reset); go to IDLE.
  - No acks are issued in INIT.
- IDLE priority: set over release. If i_pkt_bufid_req is high, latch bufid and cnt and go to SET_RD. Else, if i_release_req is high, latch bufid and go to REL_RD.
- SET_RD: read the table at the latched bufid; go to SET_WR.
- SET_WR:
  - If the old value != 0: pulse o_err_overwrite. Live count is unchanged if the new cnt != 0; decremented if the new cnt == 0.
  - If the old value == 0 and the new cnt != 0: ov_live_cnt + 1.
  - Write the new cnt.
  - Assert o_pkt_bufid_ack for exactly one cycle.
  - If cnt == 0: load ov_free_bufid and go to FREE_WAIT. Otherwise go to IDLE.
  - Set latency: request sampled in cycle t, ack visible in cycle t+2.
- REL_RD: read the table; go to REL_WR.
- REL_WR: assert o_release_ack for one cycle, then:
  - value == 0: pulse o_err_underflow; no write; go to IDLE.
  - value == 1: write 0; ov_live_cnt - 1; ov_free_bufid <= bufid; go to FREE_WAIT.
  - value > 1: write value - 1; go to IDLE.
- FREE_WAIT:
  - o_free_req = 1, ov_free_bufid stable.
  - When i_free_ack is sampled high: deassert o_free_req next cycle and go to IDLE.
  - No new set or release is accepted while in FREE_WAIT.
- Re-sampling rule: the FSM is always at least one cycle in IDLE after an ack before it samples the same requester again. This tolerates a requester that drops its req one cycle after seeing the ack.
- Arithmetic:
  - Counts are unsigned CNT_W; no wrap (underflow is blocked by the zero check).
  - ov_live_cnt saturates at DEPTH and never goes below 0.
- Simultaneous set and release on the same bufid: the set is served first. The release then sees the new count.

Test Plan:
- Reset 1 cycle -> all outputs 0; o_init_done rises after exactly 512 cycles. Requests issued during INIT are not acked.
- Set bufid 0x05, cnt 3; then three releases of 0x05 -> table 3→2→1→0. Free req with ov_free_bufid = 0x05 only after the 3rd release; ov_live_cnt 1→0.
- Set bufid 0x1FF, cnt 0 -> ack at t+2, immediate o_free_req with 0x1FF, ov_live_cnt stays 0. Hold i_free_ack low for 10 cycles -> o_free_req stays high and a pending release is not acked.
- Release of bufid 0x10 with count 0 -> o_release_ack and o_err_underflow pulse together; table and ov_live_cnt unchanged.
- Set and release requests rise in the same cycle, both for 0x20 (count previously 2), set cnt 4 -> set acked first and o_err_overwrite pulses; the release then leaves count 3.
- Assert i_rst while in FREE_WAIT -> o_free_req drops next cycle, INIT reruns, ov_live_cnt = 0, and all entries read 0 afterwards.
